iterative_divider: RTL and testbench

Multi-cycle unsigned restoring divider, the inverse of the combinational multiply unit: it recovers one factor from a 2·WORD_WIDTH-bit product and the other W-bit factor, producing one quotient bit per cycle. It sits beside the multiplier in the PE datapath for normalisation and scaling. Valid/ready handshakes run on both sides, and the block accepts one operation at a time.

---
 rtl/divider_pkg.sv | 16 +
 rtl/divider_step.sv | 30 +++
 rtl/iterative_divider.sv | 160 ++++++++++++++++
 tb/tb_iterative_divider.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types for the iterative restoring divider: FSM state encoding and
// the step-counter width helper.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Counter must hold the value 2W (number of quotient bits).
  function automatic int step_cnt_width(input int word_width);
    return $clog2(2 * word_width + 1);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring division iteration: shift in the next dividend bit, then
// subtract the divisor when the shifted remainder is large enough.
module divider_step
  import divider_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] partial_rem,
  input  logic                  next_bit,
  input  logic [WORD_WIDTH-1:0] divisor,
  output logic [WORD_WIDTH-1:0] next_rem,
  output logic                  quotient_bit
);

  logic [WORD_WIDTH:0] shifted_s;

  // Trial subtraction; the low W bits of the difference are exact because
  // the result is always below the divisor.
  always_comb begin
    shifted_s = {partial_rem, next_bit};
    if (shifted_s >= {1'b0, divisor}) begin
      next_rem     = shifted_s[WORD_WIDTH-1:0] - divisor;
      quotient_bit = 1'b1;
    end else begin
      next_rem     = shifted_s[WORD_WIDTH-1:0];
      quotient_bit = 1'b0;
    end
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle unsigned restoring divider (2W / W bits, one quotient bit per
// cycle). Optional div_by_zero flag port enabled by DIVIDER_DBZ_FLAG_EN.
module iterative_divider
  import divider_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*WORD_WIDTH-1:0] dividend,
  input  logic [WORD_WIDTH-1:0]   divisor,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*WORD_WIDTH-1:0] quotient,
  output logic [WORD_WIDTH-1:0]   remainder
`ifdef DIVIDER_DBZ_FLAG_EN
  ,
  output logic                    div_by_zero
`endif
);

  localparam int CW = step_cnt_width(WORD_WIDTH);
  localparam int DW = 2 * WORD_WIDTH;

  div_state_e            state_r;
  div_state_e            state_nxt_s;
  logic [CW-1:0]         cnt_r;
  logic [DW-1:0]         work_r;
  logic [WORD_WIDTH-1:0] rem_r;
  logic [WORD_WIDTH-1:0] divisor_r;
  logic                  zero_div_r;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic                  last_step_s;
  logic [WORD_WIDTH-1:0] step_rem_s;
  logic                  step_q_s;

  divider_step #(.WORD_WIDTH(WORD_WIDTH)) u_step (
    .partial_rem  (rem_r),
    .next_bit     (work_r[DW-1]),
    .divisor      (divisor_r),
    .next_rem     (step_rem_s),
    .quotient_bit (step_q_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a zero divisor leaves BUSY after its first cycle.
  always_comb begin
    state_nxt_s = state_r;
    last_step_s = (cnt_r == CW'(1));
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (zero_div_r || last_step_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration and result/handshake registers.
  // The quotient bits shift into work_r as the dividend bits shift out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      work_r      <= '0;
      rem_r       <= '0;
      divisor_r   <= '0;
      cnt_r       <= '0;
      zero_div_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            work_r     <= dividend;
            rem_r      <= '0;
            divisor_r  <= divisor;
            cnt_r      <= CW'(DW);
            zero_div_r <= (divisor == '0);
            in_ready_r <= 1'b0;
          end
        end
        BUSY: begin
          if (zero_div_r) begin
            work_r      <= '1;
            rem_r       <= work_r[WORD_WIDTH-1:0];
            out_valid_r <= 1'b1;
          end else begin
            work_r      <= {work_r[DW-2:0], step_q_s};
            rem_r       <= step_rem_s;
            cnt_r       <= cnt_r - CW'(1);
            out_valid_r <= last_step_s;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign quotient  = work_r;
  assign remainder = rem_r;

`ifdef DIVIDER_DBZ_FLAG_EN
  logic dbz_flag_r;

  // Flag rises with the zero-divisor result and clears on handshake.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dbz_flag_r <= 1'b0;
    end else if (state_r == BUSY && zero_div_r) begin
      dbz_flag_r <= 1'b1;
    end else if (state_r == DONE && out_ready) begin
      dbz_flag_r <= 1'b0;
    end else begin
      dbz_flag_r <= dbz_flag_r;
    end
  end

  assign div_by_zero = dbz_flag_r;
`endif

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider (W=8): cycle-level reference
// model from plain arithmetic, per-cycle compare, plus directed literal cases.
module tb_iterative_divider;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-1:0] quotient;
  logic [W-1:0]  remainder;
`ifdef DIVIDER_DBZ_FLAG_EN
  logic          div_by_zero;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  iterative_divider #(.WORD_WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIVIDER_DBZ_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: what the outputs must be, derived from / and %.
  logic           m_ready, m_valid, m_busy, m_dbz, p_dbz;
  int             m_left;
  logic [2*W-1:0] m_q, p_q;
  logic [W-1:0]   m_r, p_r;

  always @(posedge clk) begin
    started <= 1'b1;
    if (!reset_n) begin
      m_ready <= 1'b1; m_valid <= 1'b0; m_busy <= 1'b0; m_dbz <= 1'b0;
      m_left  <= 0;    m_q <= '0;       m_r <= '0;
    end else if (m_ready && in_valid) begin
      m_ready <= 1'b0;
      m_busy  <= 1'b1;
      if (divisor == 8'd0) begin
        m_left <= 1; p_q <= 16'hFFFF; p_r <= dividend[W-1:0]; p_dbz <= 1'b1;
      end else begin
        m_left <= 2 * W;
        p_q    <= dividend / {8'd0, divisor};
        p_r    <= W'(dividend % {8'd0, divisor});
        p_dbz  <= 1'b0;
      end
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_valid <= 1'b1;
        m_q <= p_q; m_r <= p_r; m_dbz <= p_dbz;
      end
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0; m_ready <= 1'b1; m_dbz <= 1'b0;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("quotient", {16'd0, quotient}, {16'd0, m_q});
        chk("remainder", {24'd0, remainder}, {24'd0, m_r});
      end
`ifdef DIVIDER_DBZ_FLAG_EN
      chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
`endif
    end
  end

  // One operation, called at a negedge with the DUT idle; optionally pins
  // latency and result to literal values.
  task automatic op(input logic [15:0] dd, input logic [7:0] dv, input int hold,
                    input bit glitch, input bit pin, input int lat_lit,
                    input logic [15:0] q_lit, input logic [7:0] r_lit);
    int n;
    in_valid = 1'b1; dividend = dd; divisor = dv; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      if (glitch) begin
        in_valid = 1'($urandom); dividend = 16'($urandom); divisor = 8'($urandom);
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (n >= 100) chk("result_timeout", 32'(n), 32'(lat_lit));
    repeat (hold) @(negedge clk);
    if (pin) begin
      chk("latency", 32'(n), 32'(lat_lit));
      chk("q_literal", {16'd0, quotient}, {16'd0, q_lit});
      chk("r_literal", {24'd0, remainder}, {24'd0, r_lit});
      if (hold > 0) chk("in_ready_held", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    logic [7:0]  rv;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_quotient", {16'd0, quotient}, 32'd0);
    chk("rst_remainder", {24'd0, remainder}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);

    op(16'd1000, 8'd7, 0, 1'b0, 1'b1, 16, 16'd142, 8'd6);
    op(16'hFFFF, 8'd1, 0, 1'b0, 1'b1, 16, 16'hFFFF, 8'd0);
    op(16'd65025, 8'd255, 0, 1'b0, 1'b1, 16, 16'd255, 8'd0);
    op(16'd5, 8'd9, 0, 1'b0, 1'b1, 16, 16'd0, 8'd5);
    op(16'h04D2, 8'd0, 0, 1'b0, 1'b1, 1, 16'hFFFF, 8'hD2);
    op(16'd1000, 8'd7, 5, 1'b1, 1'b1, 16, 16'd142, 8'd6);

    // Abort mid-BUSY after iteration 7.
    in_valid = 1'b1; dividend = 16'd12345; divisor = 8'd17;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    reset_n = 1'b1;
    op(16'd200, 8'd3, 0, 1'b0, 1'b1, 16, 16'd66, 8'd2);

    for (int i = 0; i < 40; i++) begin
      rd = 16'($urandom);
      rv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      op(rd, rv, $urandom_range(0, 3), 1'($urandom), 1'b0, 0, 16'd0, 8'd0);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
